// File: rtl/axis_frame_arbiter_if.sv
// AXI-Stream channel bundle for the frame arbiter ports.
// tdata/tvalid/tlast flow master to slave, tready flows back.
interface axis_frame_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Two-source AXI-Stream arbiter with frame-locked grants,
// round-robin tie break and per-source frame counters.
module axis_frame_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  axis_frame_arbiter_if.slave     s0,
  axis_frame_arbiter_if.slave     s1,
  axis_frame_arbiter_if.master    m,
  output logic                    m_tid,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_cnt0,
  output logic [CNT_W-1:0]        frame_cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] tdata_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      if (done0) begin
        last_grant <= 1'b0;
        frame_cnt0 <= frame_cnt0 + 1'b1;
      end
      if (done1) begin
        last_grant <= 1'b1;
        frame_cnt1 <= frame_cnt1 + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tdata_sel = '0;
    m.tvalid  = 1'b0;
    m.tlast   = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    m_tid     = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the source that did not win last time goes next
        if (s0.tvalid && s1.tvalid)
          state_nxt = last_grant ? GNT0 : GNT1;
        else if (s0.tvalid)
          state_nxt = GNT0;
        else if (s1.tvalid)
          state_nxt = GNT1;
      end
      GNT0: begin
        tdata_sel = s0.tdata;
        m.tvalid  = s0.tvalid;
        m.tlast   = s0.tlast;
        s0.tready = m.tready;
        done0     = s0.tvalid && s0.tlast && m.tready;
        if (done0)
          state_nxt = IDLE;
      end
      GNT1: begin
        tdata_sel = s1.tdata;
        m.tvalid  = s1.tvalid;
        m.tlast   = s1.tlast;
        s1.tready = m.tready;
        m_tid     = 1'b1;
        done1     = s1.tvalid && s1.tlast && m.tready;
        if (done1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m.tdata = tdata_sel;
  assign busy    = (state != IDLE);

endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of every tdata port.
REQ-002 Parameter CNT_W, default 5, SHALL set the width of each frame counter.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 s0_tdata  in  DATA_W; s0_tvalid  in  1; s0_tlast  in  1; s0_tready  out  1  SHALL form AXI-Stream slave port 0.
REQ-006 s1_tdata  in  DATA_W; s1_tvalid  in  1; s1_tlast  in  1; s1_tready  out  1  SHALL form AXI-Stream slave port 1.
REQ-007 m_tdata  out  DATA_W; m_tvalid  out  1; m_tlast  out  1; m_tready  in  1  SHALL form the shared AXI-Stream master port.
REQ-008 m_tid  out  1  SHALL give the index of the source whose beat is on the master port.
REQ-009 busy  out  1  SHALL be high while a frame is granted.
REQ-010 frame_cnt0, frame_cnt1  out  CNT_W  SHALL count completed frames per source.

Function
REQ-011 FSM states SHALL be IDLE, GNT0, GNT1.
REQ-012 IDLE: no beat transfers; m_tvalid, s0_tready and s1_tready held 0.
REQ-013 IDLE with exactly one sN_tvalid high SHALL move to GNTN on the next edge.
REQ-014 IDLE with both valid SHALL grant the source not recorded in last_grant (round-robin).
REQ-015 IDLE with neither valid SHALL remain in IDLE.
REQ-016 GNTN: m_tdata/m_tvalid/m_tlast = sN's signals combinationally; sN_tready = m_tready; other source's tready = 0; m_tid = N.
REQ-017 Datapath SHALL be zero-latency: a beat transfers on the edge where m_tvalid and m_tready are both high.
REQ-018 The grant SHALL stay locked for the whole frame; the other source's tvalid SHALL NOT preempt it.
REQ-019 A transfer with m_tlast=1 in GNTN SHALL, on that edge: go to IDLE, set last_grant=N, increment frame_cntN.
REQ-020 Exactly one IDLE cycle SHALL separate consecutive frames (arbitration bubble).
REQ-021 frame_cntN SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-022 Beats with tlast=0 SHALL NOT change the counters or the state.
REQ-023 sN_tvalid dropping mid-frame SHALL stall in GNTN (m_tvalid=0), keeping the grant.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 Single-beat frame (tvalid and tlast together) SHALL take 1 GNT cycle, then IDLE.

Reset
REQ-026 On reset assertion, immediately and regardless of clk: state=IDLE, last_grant=1, frame_cnt0=frame_cnt1=0, busy=0, m_tvalid=0, s0_tready=s1_tready=0.
REQ-027 Reset mid-frame SHALL discard the partial frame and not count it; after release source 0 wins the first tie.
REQ-028 Outputs SHALL be defined (no X) from the first edge after reset deasserts.

Verification
REQ-029 Tie after reset: both valid, s0 sends 3 beats (A0,A1,A2 with tlast), m_tready=1 -> GNT0 for 3 beats, m_tdata=A0,A1,A2, m_tid=0, frame_cnt0=1; one IDLE cycle; then GNT1.
REQ-030 Lock: s1 asserts valid during s0's beat 2 of 4 -> s1_tready stays 0 until s0's tlast; s1 granted after the bubble.
REQ-031 Backpressure: m_tready toggles 1,0,1,0 in GNT0 -> beats transfer only on m_tready=1 edges, data stable while stalled, no beat lost or duplicated.
REQ-032 Counter wrap: s1 sends 32 single-beat frames (CNT_W=5) -> frame_cnt1 reads 0 after the 32nd, frame_cnt0 unchanged.
REQ-033 Reset mid-frame: assert reset after beat 2 of a 5-beat s0 frame -> all outputs at reset values at once, frame_cnt0 unchanged from pre-frame value (0 after reset).
REQ-034 Alternation: both sources stream continuous 2-beat frames -> grants alternate 0,1,0,1 and after 8 frames frame_cnt0=frame_cnt1=4.
